ahb_slave_frontend: RTL and testbench
=====================================

// Module: ahb_slave_frontend
// PURPOSE
//  Parametrised AHB-Lite slave front-end on the AHB side of the AHB-APB bridge.
//  Tracks address/data phase pipelining and checks transfers (size, alignment, range, burst).
//  Decodes legal transfers to one of NUM_SLV downstream slots and issues one request at a time
//  on a valid/ready channel. Waits for the response and returns it as OKAY or a 2-cycle ERROR.
// PARAMETERS
//  ADDR_W      32           address width
//  DATA_W      32           data width; 8,16,32,64 only
//  NUM_SLV     4            downstream slots (power of 2, >=2)
//  SLV_SHIFT   12           slot index = Haddr[SLV_SHIFT +: $clog2(NUM_SLV)]
//  BASE_ADDR   'h8000_0000  window base; in range iff Haddr[ADDR_W-1:SLV_SHIFT+$clog2(NUM_SLV)] matches
//  CHECK_BURST 1            1: check SEQ address continuity; 0: accept any SEQ address
// PORTS
//  clock      in   1        single clock, all logic on posedge
//  Hresetn    in   1        asynchronous, active-low reset
//  Haddr      in   ADDR_W   address-phase address
//  Hwdata     in   DATA_W   write data (data phase)
//  Hsize      in   3        transfer size, bytes = 1<<Hsize
//  Hburst     in   3        0 SINGLE,1 INCR,2/3 WRAP4/INCR4,4/5 WRAP8/INCR8,6/7 WRAP16/INCR16
//  Htrans     in   2        0 IDLE,1 BUSY,2 NONSEQ,3 SEQ
//  Hwrite     in   1        1 write, 0 read
//  Hreadyin   in   1        bus ready; address phase sampled only when 1
//  Hreadyout  out  1        data-phase completion
//  Hresp      out  2        00 OKAY, 01 ERROR
//  Hrdata     out  DATA_W   read data, registered
//  req_valid  out  1        downstream request valid
//  req_ready  in   1        downstream accepts request
//  req_write  out  1        request direction
//  req_addr   out  ADDR_W   latched address
//  req_wdata  out  DATA_W   latched write data (0 for reads)
//  req_size   out  3        latched Hsize
//  req_sel    out  NUM_SLV  one-hot slot select, stable while req_valid
//  rsp_valid  in   1        downstream response strobe (1 cycle)
//  rsp_rdata  in   DATA_W   response read data
//  rsp_err    in   1        response error
// BEHAVIOUR
//  Reset (async, Hresetn=0):
//   - state=IDLE, Hreadyout=1, Hresp=00.
//   - Hrdata, req_* = 0; burst tracker cleared.
//   - Reset mid-transaction drops req_valid immediately; no response is replayed.
//  Sample rule (states IDLE and DONE only):
//   - Address phase taken iff Hreadyin=1 and Htrans is NONSEQ or SEQ.
//   - IDLE/BUSY transfers give zero-wait OKAY and no request.
//  Error on sample:
//   - out of range; Hsize > log2(DATA_W/8); Haddr misaligned to 1<<Hsize;
//   - SEQ with no active burst; CHECK_BURST=1 and SEQ addr != expected.
//  FSM:
//   IDLE/DONE  Hreadyout=1. Legal sample -> DATA, latch addr/write/size/sel. Error -> ERR1.
//              Else IDLE.
//   DATA       Hreadyout=0; latch Hwdata if write -> REQ.
//   REQ        req_valid=1, Hreadyout=0; req_ready=1 -> WAIT.
//   WAIT       Hreadyout=0; rsp_valid: rsp_err=0 -> DONE with Hrdata<=rsp_rdata (reads);
//              rsp_err=1 -> ERR1.
//   ERR1       Hreadyout=0, Hresp=01 -> ERR2.
//   ERR2       Hreadyout=1, Hresp=01; burst tracker cleared; next sample ignored -> IDLE.
//  Minimum latency: 3 wait states plus downstream delays (addr sample -> Hreadyout=1 in DONE).
//  Burst tracker:
//   - NONSEQ starts it; beats=1,4,8,16 by Hburst; INCR is unbounded.
//   - Expected next = addr + (1<<size).
//   - WRAPn: wraps within an n*(1<<size)-aligned block.
//   - Burst ends after final beat; a NONSEQ mid-burst restarts it.
//   - BUSY holds the tracker.
//  Hrdata holds its value until the next read completes; rsp_valid outside WAIT is ignored.
// TESTING
//  - Reset: Hresetn=0 mid-REQ -> req_valid=0 same cycle, Hreadyout=1, Hresp=00 on release.
//  - Single write 0x8000_1004, Hwdata=0xDEAD_BEEF, req_ready/rsp_valid immediate
//    -> req_sel=4'b0010, req_wdata=0xDEAD_BEEF, Hreadyout=1 3 cycles after sample.
//  - Read 0x8000_3000, rsp_rdata=0x1234_5678 with 2-cycle rsp delay -> Hrdata=0x1234_5678, OKAY.
//  - WRAP4 word read from 0x8000_0008 -> beats 08,0C,00,04 OKAY; SEQ to 0x10 instead -> ERROR pair.
//  - Haddr=0x7000_0000, or 0x8000_0002 with Hsize=2 -> ERR1/ERR2, no req_valid.
//  - rsp_err=1 on write -> Hresp=01 two cycles, Hreadyout 0 then 1.

Source files
------------

// File: rtl/ahb_slave_frontend.sv
// AHB-Lite slave front-end for the AHB-APB bridge.
// Checks each address phase, decodes it to one downstream slot and issues
// one request at a time on a valid/ready channel. The downstream response
// comes back to the bus as OKAY or as a two-cycle ERROR.
`timescale 1ns/1ps
module ahb_slave_frontend #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_SLV     = 4,
    parameter int unsigned       SLV_SHIFT   = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
    parameter bit                CHECK_BURST = 1'b1
) (
    input  logic               clock,
    input  logic               Hresetn,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    input  logic [2:0]         Hsize,
    input  logic [2:0]         Hburst,
    input  logic [1:0]         Htrans,
    input  logic               Hwrite,
    input  logic               Hreadyin,
    output logic               Hreadyout,
    output logic [1:0]         Hresp,
    output logic [DATA_W-1:0]  Hrdata,
    output logic               req_valid,
    input  logic               req_ready,
    output logic               req_write,
    output logic [ADDR_W-1:0]  req_addr,
    output logic [DATA_W-1:0]  req_wdata,
    output logic [2:0]         req_size,
    output logic [NUM_SLV-1:0] req_sel,
    input  logic               rsp_valid,
    input  logic [DATA_W-1:0]  rsp_rdata,
    input  logic               rsp_err
);

    localparam int unsigned SEL_W    = $clog2(NUM_SLV);
    localparam int unsigned TOP_LSB  = SLV_SHIFT + SEL_W;
    localparam int unsigned MAX_SIZE = $clog2(DATA_W / 8);

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DATA, ST_REQ, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2
    } state_t;

    state_t state, state_n;

    // burst tracker
    logic              trk_active;
    logic [2:0]        trk_burst;
    logic [4:0]        trk_left;
    logic [ADDR_W-1:0] trk_next;

    logic              is_seq, take, in_range, size_bad, misaligned, seq_bad, xfer_err;
    logic [ADDR_W-1:0] size_mask, wrap_mask, incr, sum, next_addr;
    logic [2:0]        burst_sel;
    logic              is_wrap;
    logic [3:0]        wrap_sh;
    logic [4:0]        burst_len;

    // Address-phase qualification and legality checks
    always_comb begin
        is_seq     = (Htrans == TR_SEQ);
        take       = Hreadyin && (Htrans == TR_NONSEQ || is_seq) &&
                     (state == ST_IDLE || state == ST_DONE);
        in_range   = (Haddr[ADDR_W-1:TOP_LSB] == BASE_ADDR[ADDR_W-1:TOP_LSB]);
        size_bad   = (Hsize > 3'(MAX_SIZE));
        size_mask  = ~({ADDR_W{1'b1}} << Hsize);
        misaligned = |(Haddr & size_mask);
        seq_bad    = is_seq && (!trk_active || (CHECK_BURST && (Haddr != trk_next)));
        xfer_err   = !in_range || size_bad || misaligned || seq_bad;
    end

    // Next expected burst address; SEQ beats follow the burst type captured at NONSEQ
    always_comb begin
        burst_sel = is_seq ? trk_burst : Hburst;
        is_wrap   = !burst_sel[0] && (burst_sel[2:1] != 2'b00);
        incr      = {{(ADDR_W-1){1'b0}}, 1'b1} << Hsize;
        sum       = Haddr + incr;
        wrap_sh   = {1'b0, Hsize} + {2'b00, burst_sel[2:1]} + 4'd1;
        wrap_mask = ~({ADDR_W{1'b1}} << wrap_sh);
        next_addr = is_wrap ? ((Haddr & ~wrap_mask) | (sum & wrap_mask)) : sum;
        case (Hburst[2:1])
            2'b01:   burst_len = 5'd4;
            2'b10:   burst_len = 5'd8;
            2'b11:   burst_len = 5'd16;
            default: burst_len = 5'd1;
        endcase
    end

    // Burst tracker: started by NONSEQ, advanced by SEQ, held by BUSY/IDLE
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            trk_active <= 1'b0;
            trk_burst  <= '0;
            trk_left   <= '0;
            trk_next   <= '0;
        end else if (state == ST_ERR2) begin
            trk_active <= 1'b0;
            trk_left   <= '0;
        end else if (take && !xfer_err) begin
            trk_next <= next_addr;
            if (!is_seq) begin
                trk_burst  <= Hburst;
                trk_left   <= burst_len - 5'd1;
                trk_active <= (Hburst != HB_SINGLE);
            end else if (trk_burst != HB_INCR) begin
                // INCR never counts down; fixed-length bursts end after the last beat
                trk_left   <= trk_left - 5'd1;
                trk_active <= (trk_left != 5'd1);
            end
        end
    end

    // Request latches and registered read data
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            req_addr  <= '0;
            req_write <= 1'b0;
            req_size  <= '0;
            req_sel   <= '0;
            req_wdata <= '0;
            Hrdata    <= '0;
        end else begin
            if (take && !xfer_err) begin
                req_addr  <= Haddr;
                req_write <= Hwrite;
                req_size  <= Hsize;
                req_sel   <= {{(NUM_SLV-1){1'b0}}, 1'b1} << Haddr[SLV_SHIFT +: SEL_W];
            end
            if (state == ST_DATA) begin
                req_wdata <= req_write ? Hwdata : '0;
            end
            if (state == ST_WAIT && rsp_valid && !rsp_err && !req_write) begin
                Hrdata <= rsp_rdata;
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and bus/request outputs
    always_comb begin
        state_n   = state;
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        req_valid = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (take) begin
                    state_n = xfer_err ? ST_ERR1 : ST_DATA;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                Hreadyout = 1'b0;
                state_n   = ST_REQ;
            end
            ST_REQ: begin
                Hreadyout = 1'b0;
                req_valid = 1'b1;
                if (req_ready) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                Hreadyout = 1'b0;
                if (rsp_valid) begin
                    state_n = rsp_err ? ST_ERR1 : ST_DONE;
                end
            end
            ST_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = 2'b01;
                state_n   = ST_ERR2;
            end
            ST_ERR2: begin
                // address phase presented alongside the second ERROR cycle is dropped
                Hresp   = 2'b01;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_frontend.sv
// Bench for ahb_slave_frontend: table of single transfers, hand-written
// burst/reset/stray-response sequences, and a downstream responder that
// checks each issued request against a queue of expected requests.
`timescale 1ns/1ps
module tb_ahb_slave_frontend;

    logic        clock = 1'b0;
    logic        Hresetn;
    logic [31:0] Haddr, Hwdata, Hrdata;
    logic [2:0]  Hsize, Hburst;
    logic [1:0]  Htrans, Hresp;
    logic        Hwrite, Hreadyin, Hreadyout;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clock = ~clock;

    ahb_slave_frontend #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_SHIFT(12),
        .BASE_ADDR(32'h8000_0000), .CHECK_BURST(1'b1)
    ) dut (
        .clock(clock), .Hresetn(Hresetn), .Haddr(Haddr), .Hwdata(Hwdata),
        .Hsize(Hsize), .Hburst(Hburst), .Htrans(Htrans), .Hwrite(Hwrite),
        .Hreadyin(Hreadyin), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_sel(req_sel), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [3:0]  sel;
    } req_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          waits;
    } rsp_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [1:0]  trans;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        rerr;
        int          rdy_dly;
        int          rsp_dly;
        logic        exp_err;
        logic        exp_req;
        logic [3:0]  sel;
    } vec_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_rdata = 32'h0;

    int          cfg_rdy_dly = 0;
    int          cfg_rsp_dly = 0;
    logic [31:0] cfg_rdata   = 32'h0;
    logic        cfg_err     = 1'b0;
    int          stray_req   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Downstream slot model: accepts requests after cfg_rdy_dly cycles and
    // answers cfg_rsp_dly cycles later; checks each request when accepted
    initial begin : responder
        int   rdy_cnt   = 0;
        int   rsp_cnt   = 0;
        int   stray_own = 0;
        bit   pending   = 1'b0;
        req_t r;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0;
        forever begin
            @(negedge clock);
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            if (!Hresetn) begin
                rdy_cnt = 0;
                pending = 1'b0;
                exp_req.delete();
            end else if (stray_own != stray_req) begin
                stray_own = stray_req;
                rsp_valid = 1'b1;
                rsp_rdata = 32'hFFFF_FFFF;
            end else if (req_valid) begin
                if (rdy_cnt >= cfg_rdy_dly) begin
                    req_ready = 1'b1;
                    rdy_cnt   = 0;
                    rsp_cnt   = 0;
                    pending   = 1'b1;
                    if (exp_req.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_req: got addr 0x%0h, want no request", req_addr);
                    end else begin
                        r = exp_req.pop_front();
                        chk("req_addr",  req_addr,         r.addr);
                        chk("req_write", 32'(req_write),   32'(r.wr));
                        chk("req_wdata", req_wdata,        r.wdata);
                        chk("req_size",  32'(req_size),    32'(r.size));
                        chk("req_sel",   32'(req_sel),     32'(r.sel));
                    end
                end else begin
                    rdy_cnt++;
                end
            end else if (pending) begin
                if (rsp_cnt >= cfg_rsp_dly) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = cfg_rdata;
                    rsp_err   = cfg_err;
                    pending   = 1'b0;
                end else begin
                    rsp_cnt++;
                end
            end
        end
    end

    // One AHB transfer, driven at a negedge where the slave is ready; returns
    // at the negedge where its data phase completes (or after the ERROR pair)
    task automatic bus_xfer(input string name, input logic [31:0] addr, input logic wr,
                            input logic [2:0] size, input logic [2:0] burst, input logic [1:0] trans,
                            input logic [31:0] wdata, input logic [31:0] rdata, input logic rerr,
                            input int rdy_dly, input int rsp_dly, input logic exp_err,
                            input logic exp_req_flag, input logic [3:0] sel);
        rsp_t       e;
        req_t       r;
        int         waits;
        logic [1:0] prev_resp;
        cfg_rdy_dly = rdy_dly;
        cfg_rsp_dly = rsp_dly;
        cfg_rdata   = rdata;
        cfg_err     = rerr;
        Haddr  = addr;
        Hwrite = wr;
        Hsize  = size;
        Hburst = burst;
        Htrans = trans;
        if (exp_req_flag) begin
            r.addr  = addr;
            r.wr    = wr;
            r.wdata = wr ? wdata : 32'h0;
            r.size  = size;
            r.sel   = sel;
            exp_req.push_back(r);
            if (!wr && !rerr) m_rdata = rdata;
        end
        e.resp  = exp_err ? 2'b01 : 2'b00;
        e.rdata = m_rdata;
        e.waits = exp_req_flag ? (3 + rdy_dly + rsp_dly + (rerr ? 1 : 0)) : (exp_err ? 1 : 0);
        exp_rsp.push_back(e);
        @(negedge clock);
        Htrans    = 2'b00;
        Hwdata    = wdata;
        waits     = 0;
        prev_resp = 2'b00;
        while (Hreadyout !== 1'b1 && waits < 64) begin
            prev_resp = Hresp;
            waits++;
            @(negedge clock);
        end
        e = exp_rsp.pop_front();
        chk({name, "_waits"},  32'(waits), 32'(e.waits));
        chk({name, "_hresp"},  32'(Hresp), 32'(e.resp));
        chk({name, "_hrdata"}, Hrdata,     e.rdata);
        if (e.resp == 2'b01) begin
            chk({name, "_err1"}, 32'(prev_resp), 32'h1);
            @(negedge clock);
        end
    endtask

    vec_t tbl[16];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin : main
        int wt;
        tbl[0]  = '{"wr_single",  32'h8000_1004, 1'b1, 3'd2, 3'd0, 2'b10, 32'hDEAD_BEEF, 32'h0,         1'b0, 0, 0, 1'b0, 1'b1, 4'b0010};
        tbl[1]  = '{"rd_slot3",   32'h8000_3000, 1'b0, 3'd2, 3'd0, 2'b10, 32'h0,         32'h1234_5678, 1'b0, 0, 2, 1'b0, 1'b1, 4'b1000};
        tbl[2]  = '{"out_low",    32'h7000_0000, 1'b0, 3'd2, 3'd0, 2'b10, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 1'b0, 4'b0000};
        tbl[3]  = '{"misalign_w", 32'h8000_0002, 1'b0, 3'd2, 3'd0, 2'b10, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 1'b0, 4'b0000};
        tbl[4]  = '{"oversize",   32'h8000_0000, 1'b0, 3'd3, 3'd0, 2'b10, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 1'b0, 4'b0000};
        tbl[5]  = '{"out_high",   32'h8000_4000, 1'b0, 3'd2, 3'd0, 2'b10, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 1'b0, 4'b0000};
        tbl[6]  = '{"hw_wr",      32'h8000_2002, 1'b1, 3'd1, 3'd0, 2'b10, 32'h0000_CAFE, 32'h0,         1'b0, 1, 1, 1'b0, 1'b1, 4'b0100};
        tbl[7]  = '{"byte_rd",    32'h8000_0003, 1'b0, 3'd0, 3'd0, 2'b10, 32'h0,         32'hA5A5_0011, 1'b0, 2, 0, 1'b0, 1'b1, 4'b0001};
        tbl[8]  = '{"wr_rsperr",  32'h8000_1000, 1'b1, 3'd2, 3'd0, 2'b10, 32'h0BAD_F00D, 32'h0,         1'b1, 0, 0, 1'b1, 1'b1, 4'b0010};
        tbl[9]  = '{"rd_rsperr",  32'h8000_2000, 1'b0, 3'd2, 3'd0, 2'b10, 32'h0,         32'h5555_AAAA, 1'b1, 0, 1, 1'b1, 1'b1, 4'b0100};
        tbl[10] = '{"idle_trans", 32'h7000_0001, 1'b0, 3'd3, 3'd0, 2'b00, 32'h0,         32'h0,         1'b0, 0, 0, 1'b0, 1'b0, 4'b0000};
        tbl[11] = '{"busy_trans", 32'h8000_0000, 1'b0, 3'd2, 3'd1, 2'b01, 32'h0,         32'h0,         1'b0, 0, 0, 1'b0, 1'b0, 4'b0000};
        tbl[12] = '{"seq_noburst",32'h8000_0004, 1'b0, 3'd2, 3'd1, 2'b11, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 1'b0, 4'b0000};
        tbl[13] = '{"misalign_h", 32'h8000_0001, 1'b1, 3'd1, 3'd0, 2'b10, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 1'b0, 4'b0000};
        tbl[14] = '{"rd_slot0_top",32'h8000_0FFC,1'b0, 3'd2, 3'd0, 2'b10, 32'h0,         32'h0F0F_F0F0, 1'b0, 0, 0, 1'b0, 1'b1, 4'b0001};
        tbl[15] = '{"wr_win_top", 32'h8000_3FFC, 1'b1, 3'd2, 3'd0, 2'b10, 32'h1111_2222, 32'h0,         1'b0, 1, 0, 1'b0, 1'b1, 4'b1000};

        Hresetn  = 1'b0;
        Haddr    = 32'h0;
        Hwdata   = 32'h0;
        Hsize    = 3'd0;
        Hburst   = 3'd0;
        Htrans   = 2'b00;
        Hwrite   = 1'b0;
        Hreadyin = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_hreadyout", 32'(Hreadyout), 32'h1);
        chk("rst_hresp",     32'(Hresp),     32'h0);
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_hrdata",    Hrdata,         32'h0);
        chk("rst_req_addr",  req_addr,       32'h0);
        chk("rst_req_wdata", req_wdata,      32'h0);
        chk("rst_req_sel",   32'(req_sel),   32'h0);
        Hresetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 16; i++) begin
            bus_xfer(tbl[i].name, tbl[i].addr, tbl[i].wr, tbl[i].size, tbl[i].burst, tbl[i].trans,
                     tbl[i].wdata, tbl[i].rdata, tbl[i].rerr, tbl[i].rdy_dly, tbl[i].rsp_dly,
                     tbl[i].exp_err, tbl[i].exp_req, tbl[i].sel);
        end

        // WRAP4 word read from 0x08 wraps to 0x00, then SEQ after the last beat is illegal
        bus_xfer("w4_b0", 32'h8000_0008, 1'b0, 3'd2, 3'd2, 2'b10, 32'h0, 32'h0000_0100, 1'b0, 0, 0, 1'b0, 1'b1, 4'b0001);
        bus_xfer("w4_b1", 32'h8000_000C, 1'b0, 3'd2, 3'd2, 2'b11, 32'h0, 32'h0000_0101, 1'b0, 0, 1, 1'b0, 1'b1, 4'b0001);
        bus_xfer("w4_b2", 32'h8000_0000, 1'b0, 3'd2, 3'd2, 2'b11, 32'h0, 32'h0000_0102, 1'b0, 1, 0, 1'b0, 1'b1, 4'b0001);
        bus_xfer("w4_b3", 32'h8000_0004, 1'b0, 3'd2, 3'd2, 2'b11, 32'h0, 32'h0000_0103, 1'b0, 0, 0, 1'b0, 1'b1, 4'b0001);
        bus_xfer("w4_past_end", 32'h8000_0008, 1'b0, 3'd2, 3'd2, 2'b11, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 1'b0, 4'b0000);

        // WRAP4 with SEQ to 0x10 instead of the wrapped 0x00
        bus_xfer("w4x_b0", 32'h8000_0008, 1'b0, 3'd2, 3'd2, 2'b10, 32'h0, 32'h0000_0200, 1'b0, 0, 0, 1'b0, 1'b1, 4'b0001);
        bus_xfer("w4x_b1", 32'h8000_000C, 1'b0, 3'd2, 3'd2, 2'b11, 32'h0, 32'h0000_0201, 1'b0, 0, 0, 1'b0, 1'b1, 4'b0001);
        bus_xfer("w4x_nowrap", 32'h8000_0010, 1'b0, 3'd2, 3'd2, 2'b11, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 1'b0, 4'b0000);

        // INCR4 write: BUSY holds the tracker, skipped address is rejected
        bus_xfer("i4_b0",   32'h8000_0000, 1'b1, 3'd2, 3'd3, 2'b10, 32'hAAAA_0000, 32'h0, 1'b0, 0, 0, 1'b0, 1'b1, 4'b0001);
        bus_xfer("i4_busy", 32'h8000_0004, 1'b1, 3'd2, 3'd3, 2'b01, 32'h0,         32'h0, 1'b0, 0, 0, 1'b0, 1'b0, 4'b0000);
        bus_xfer("i4_b1",   32'h8000_0004, 1'b1, 3'd2, 3'd3, 2'b11, 32'hAAAA_0004, 32'h0, 1'b0, 0, 0, 1'b0, 1'b1, 4'b0001);
        bus_xfer("i4_skip", 32'h8000_000C, 1'b1, 3'd2, 3'd3, 2'b11, 32'hAAAA_000C, 32'h0, 1'b0, 0, 0, 1'b1, 1'b0, 4'b0000);

        // A response strobe with no transfer outstanding changes nothing
        stray_req++;
        repeat (3) @(negedge clock);
        chk("stray_hrdata",    Hrdata,         m_rdata);
        chk("stray_hreadyout", 32'(Hreadyout), 32'h1);
        chk("stray_req_valid", 32'(req_valid), 32'h0);

        // Reset while a request is waiting for req_ready
        cfg_rdy_dly = 50;
        Haddr  = 32'h8000_2004;
        Hwrite = 1'b1;
        Hsize  = 3'd2;
        Hburst = 3'd0;
        Htrans = 2'b10;
        @(negedge clock);
        Htrans = 2'b00;
        Hwdata = 32'h0123_4567;
        wt = 0;
        while (req_valid !== 1'b1 && wt < 10) begin
            wt++;
            @(negedge clock);
        end
        chk("rst_mid_req_reached", 32'(req_valid), 32'h1);
        #2 Hresetn = 1'b0;
        #1;
        chk("rst_mid_req_valid",  32'(req_valid), 32'h0);
        chk("rst_mid_hreadyout",  32'(Hreadyout), 32'h1);
        chk("rst_mid_hresp",      32'(Hresp),     32'h0);
        chk("rst_mid_req_sel",    32'(req_sel),   32'h0);
        chk("rst_mid_hrdata",     Hrdata,         32'h0);
        m_rdata = 32'h0;
        @(negedge clock);
        Hresetn = 1'b1;
        @(negedge clock);
        chk("rel_hreadyout", 32'(Hreadyout), 32'h1);
        chk("rel_hresp",     32'(Hresp),     32'h0);
        chk("rel_req_valid", 32'(req_valid), 32'h0);
        bus_xfer("post_rst_rd", 32'h8000_1008, 1'b0, 3'd2, 3'd0, 2'b10, 32'h0, 32'h7777_8888, 1'b0, 0, 0, 1'b0, 1'b1, 4'b0010);

        if (exp_req.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL req_drain: got %0d requests never issued, want 0", exp_req.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
